// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, exception/interrupt entry, mfc0/mtc0/eret. `CP0_BD_EN enables delay-slot BD/EPC.
// Latency: exc_int and dout are combinational in the same cycle; state updates on the next rising edge.
// Backpressure: none; exc_int is a same-cycle flush request that the pipeline must honour.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2020_0715
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc4_M,
  input  logic        bd_M,
  input  logic [6:2]  exccode_M,
  input  logic [5:0]  hwint,
  input  logic        exl_clr,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        exc_int
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [6:2]  exc_code;
  logic [31:0] epc;
  logic        bd;
  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_entry;

  assign int_req = (|(hwint & im)) & ie & ~exl;
  assign exc_req = (exccode_M != 5'd0) & ~exl;
  assign exc_int = (int_req | exc_req) & ~reset;

`ifdef CP0_BD_EN
  // A faulting delay-slot instruction restarts at its branch, one word earlier.
  assign epc_entry = bd_M ? (pc4_M - 32'd8) : (pc4_M - 32'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd <= 1'b0;
    end else if (exc_int) begin
      bd <= bd_M;
    end
  end
`else
  logic unused_bd;
  assign unused_bd = bd_M;
  assign bd        = 1'b0;
  assign epc_entry = pc4_M - 32'd4;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= hwint;
      if (exc_int) begin
        // Entry swallows any mtc0/eret in the same cycle.
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : exccode_M;
        epc      <= {epc_entry[31:2], 2'b00};
      end else begin
        if (we && (A2 == 5'd12)) begin
          im  <= din[15:10];
          ie  <= din[0];
          exl <= din[1];
        end
        if (exl_clr) begin
          exl <= 1'b0;
        end
        if (we && (A2 == 5'd14)) begin
          epc <= {din[31:2], 2'b00};
        end
      end
    end
  end

  always_comb begin
    dout = 32'd0;
    case (A1)
      5'd12:   dout = {16'd0, im, 8'd0, exl, ie};
      5'd13:   dout = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
      5'd14:   dout = epc;
      5'd15:   dout = PRID;
      default: dout = 32'd0;
    endcase
  end

  assign epc_out = epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic against a register-level model.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2020_0715;
`ifdef CP0_BD_EN
  localparam bit BD_EN = 1'b1;
`else
  localparam bit BD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc4_M;
  logic        bd_M;
  logic [6:2]  exccode_M;
  logic [5:0]  hwint;
  logic        exl_clr;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        exc_int;

  cp0_unit #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .din(din), .we(we),
    .pc4_M(pc4_M), .bd_M(bd_M), .exccode_M(exccode_M), .hwint(hwint),
    .exl_clr(exl_clr), .dout(dout), .epc_out(epc_out), .exc_int(exc_int)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Architectural view of the registers as whole 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_int_req();
    return (|(hwint & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc_int();
    if (reset) return 1'b0;
    return m_int_req() || ((exccode_M != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr    = 32'd0;
    m_cause = 32'd0;
    m_epc   = 32'd0;
  endtask

  task automatic idle();
    A1 = 5'd0; A2 = 5'd0; din = 32'd0; we = 1'b0; pc4_M = 32'd0;
    bd_M = 1'b0; exccode_M = 5'd0; hwint = 6'd0; exl_clr = 1'b0;
  endtask

  // Advance the model with the current inputs, then cross one rising edge.
  task automatic tick();
    logic        take;
    logic        irq;
    logic [31:0] back;
    if (reset) begin
      model_reset();
    end else begin
      take = m_exc_int();
      irq  = m_int_req();
      if (take) begin
        m_cause[6:2] = irq ? 5'd0 : exccode_M;
        back         = (BD_EN && bd_M) ? 32'd8 : 32'd4;
        m_epc        = (pc4_M - back) & 32'hFFFF_FFFC;
        m_cause[31]  = BD_EN && bd_M;
        m_sr[1]      = 1'b1;
      end else begin
        if (we && A2 == 5'd12) m_sr = din & 32'h0000_FC03;
        if (exl_clr) m_sr[1] = 1'b0;
        if (we && A2 == 5'd14) m_epc = din & 32'hFFFF_FFFC;
      end
      m_cause[15:10] = hwint;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    idle();
    reset = 1'b1;
    model_reset();
    A1 = 5'd15;
    #1;
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL reset_exc_int got %b want 0", exc_int); end
    checks++; if (dout !== PRID) begin failures++; $display("FAIL reset_prid got %h want %h", dout, PRID); end
    checks++; if (epc_out !== 32'd0) begin failures++; $display("FAIL reset_epc_out got %h want 0", epc_out); end
    exccode_M = 5'd5;
    #1;
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL reset_masks_exc got %b want 0", exc_int); end
    exccode_M = 5'd0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    exccode_M = 5'd3; pc4_M = 32'h100;
    #1;
    checks++; if (exc_int !== 1'b1) begin failures++; $display("FAIL pre_reset_entry got %b want 1", exc_int); end
    tick();
    exccode_M = 5'd0; A1 = 5'd12;
    #1;
    checks++; if (dout !== 32'h2) begin failures++; $display("FAIL pre_reset_exl got %h want 2", dout); end
    // Reset asserted mid-cycle while EXL=1 and an exception is presented.
    exccode_M = 5'd7;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL midreset_exc_int got %b want 0", exc_int); end
    checks++; if (epc_out !== 32'd0) begin failures++; $display("FAIL midreset_epc_out got %h want 0", epc_out); end
    for (int a = 12; a <= 15; a++) begin
      A1 = 5'(a);
      exp = (a == 15) ? PRID : 32'd0;
      #1;
      checks++; if (dout !== exp) begin failures++; $display("FAIL midreset_read_%0d got %h want %h", a, dout, exp); end
    end
    tick();
    #1;
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL reset_hold_exc_int got %b want 0", exc_int); end
    reset = 1'b0;
    idle();
    #1;
  endtask

  task automatic test_exception_entry();
    idle();
    exccode_M = 5'd10; pc4_M = 32'h3008;
    #1;
    checks++; if (exc_int !== 1'b1) begin failures++; $display("FAIL entry_same_cycle got %b want 1", exc_int); end
    tick();
    A1 = 5'd13;
    #1;
    checks++; if (dout !== 32'h0000_0028) begin failures++; $display("FAIL entry_cause got %h want 00000028", dout); end
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL entry_masked got %b want 0", exc_int); end
    A1 = 5'd14;
    #1;
    checks++; if (dout !== 32'h3004) begin failures++; $display("FAIL entry_epc got %h want 00003004", dout); end
    checks++; if (epc_out !== 32'h3004) begin failures++; $display("FAIL entry_epc_out got %h want 00003004", epc_out); end
    A1 = 5'd12;
    #1;
    checks++; if (dout[1] !== 1'b1) begin failures++; $display("FAIL entry_exl got %b want 1", dout[1]); end
    idle();
    exl_clr = 1'b1;
    tick();
    idle();
    #1;
  endtask

  task automatic test_int_priority();
    idle();
    we = 1'b1; A2 = 5'd12; din = 32'h0000_0401;
    tick();
    idle();
    hwint = 6'b000001; exccode_M = 5'd4; pc4_M = 32'h4000;
    #1;
    checks++; if (exc_int !== 1'b1) begin failures++; $display("FAIL irq_request got %b want 1", exc_int); end
    tick();
    exccode_M = 5'd0; A1 = 5'd13;
    #1;
    checks++; if (dout !== 32'h0000_0400) begin failures++; $display("FAIL irq_cause got %h want 00000400", dout); end
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL irq_masked got %b want 0", exc_int); end
    idle();
    exl_clr = 1'b1; we = 1'b1; A2 = 5'd12; din = 32'd0;
    tick();
    idle();
    #1;
  endtask

  task automatic test_delay_slot();
    logic [31:0] exp_epc, exp_cause;
    idle();
    pc4_M = 32'h3010; bd_M = 1'b1; exccode_M = 5'd12;
    exp_epc   = BD_EN ? 32'h3008 : 32'h300C;
    exp_cause = BD_EN ? 32'h8000_0030 : 32'h0000_0030;
    tick();
    idle();
    A1 = 5'd14;
    #1;
    checks++; if (dout !== exp_epc) begin failures++; $display("FAIL bd_epc got %h want %h", dout, exp_epc); end
    A1 = 5'd13;
    #1;
    checks++; if (dout !== exp_cause) begin failures++; $display("FAIL bd_cause got %h want %h", dout, exp_cause); end
    idle();
    exl_clr = 1'b1;
    tick();
    idle();
    #1;
  endtask

  task automatic test_collision();
    idle();
    we = 1'b1; A2 = 5'd14; din = 32'h1234; exccode_M = 5'd5; pc4_M = 32'h3100;
    tick();
    idle();
    #1;
    checks++; if (epc_out !== 32'h30FC) begin failures++; $display("FAIL collide_epc got %h want 000030fc", epc_out); end
    A1 = 5'd13;
    #1;
    checks++; if (dout !== 32'h0000_0014) begin failures++; $display("FAIL collide_cause got %h want 00000014", dout); end
    idle();
    exl_clr = 1'b1;
    tick();
    idle();
    #1;
  endtask

  task automatic test_eret_pending();
    idle();
    we = 1'b1; A2 = 5'd12; din = 32'h0000_0403;
    tick();
    idle();
    A1 = 5'd12;
    #1;
    checks++; if (dout !== 32'h0000_0403) begin failures++; $display("FAIL eret_sr_setup got %h want 00000403", dout); end
    hwint = 6'b000001;
    #1;
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL eret_exl_masks got %b want 0", exc_int); end
    exl_clr = 1'b1;
    #1;
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL eret_same_cycle got %b want 0", exc_int); end
    tick();
    exl_clr = 1'b0;
    #1;
    checks++; if (exc_int !== 1'b1) begin failures++; $display("FAIL eret_next_irq got %b want 1", exc_int); end
    tick();
    #1;
    checks++; if (dout !== 32'h0000_0403) begin failures++; $display("FAIL eret_reentry_sr got %h want 00000403", dout); end
    checks++; if (exc_int !== 1'b0) begin failures++; $display("FAIL eret_reentry_masked got %b want 0", exc_int); end
    idle();
    exl_clr = 1'b1; we = 1'b1; A2 = 5'd12; din = 32'h0000_0403;
    tick();
    idle();
    A1 = 5'd12;
    #1;
    checks++; if (dout !== 32'h0000_0401) begin failures++; $display("FAIL eret_beats_mtc0 got %h want 00000401", dout); end
    we = 1'b1; A2 = 5'd12; din = 32'd0;
    tick();
    idle();
    #1;
  endtask

  task automatic test_random();
    logic [31:0] exp_dout;
    logic        exp_exc;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
      A1        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(11, 16));
      A2        = 5'($urandom_range(11, 16));
      din       = $urandom;
      we        = ($urandom_range(0, 3) == 0);
      pc4_M     = $urandom;
      bd_M      = 1'($urandom);
      exccode_M = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      hwint     = 6'($urandom);
      exl_clr   = ($urandom_range(0, 4) == 0);
      #1;
      exp_exc  = m_exc_int();
      exp_dout = m_read(A1);
      checks++; if (exc_int !== exp_exc) begin failures++; $display("FAIL rand_exc_int i=%0d got %b want %b", i, exc_int, exp_exc); end
      checks++; if (dout !== exp_dout) begin failures++; $display("FAIL rand_dout i=%0d A1=%0d got %h want %h", i, A1, dout, exp_dout); end
      checks++; if (epc_out !== m_epc) begin failures++; $display("FAIL rand_epc_out i=%0d got %h want %h", i, epc_out, m_epc); end
      tick();
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_exception_entry();
    test_int_priority();
    test_delay_slot();
    test_collision();
    test_eret_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
